serial_bit_adder: RTL and testbench
===================================

// Module: serial_bit_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder: accepts two operands over a valid/ready handshake, adds LSB-first one bit per clock.
//  Per-bit datapath is a half-adder pair plus a carry flip-flop (full-add of a_i, b_i, carry).
//  Sits downstream of operand sources; feeds sum/carry to consumers over a second valid/ready handshake.
//  Area-optimised alternative to parallel adders for multi-bit words.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range >= 1
//  (localparam CNT_W = $clog2(WIDTH+1), bit-counter width)
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a/b valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  a          in   WIDTH  operand A, sampled on accept edge
//  b          in   WIDTH  operand B, sampled on accept edge
//  out_valid  out  1      sum/carry valid (DONE only)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a+b modulo 2^WIDTH
//  carry      out  1      carry-out of bit WIDTH-1
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, sum=0, carry=0, counter=0, operand regs=0.
//  States: IDLE -> ADD -> DONE -> IDLE.
//  IDLE: in_ready=1. Edge with in_valid=1: load a_sr<=a, b_sr<=b, c<=0, cnt<=0, -> ADD.
//   in_valid=0: stay IDLE, nothing changes.
//  ADD: in_ready=0, out_valid=0. Each edge:
//   s = a_sr[0]^b_sr[0]^c; c <= majority(a_sr[0],b_sr[0],c);
//   a_sr,b_sr shift right 1; sum_sr <= {s, sum_sr[WIDTH-1:1]}; cnt <= cnt+1.
//   On edge where cnt==WIDTH-1: -> DONE; carry <= final carry; sum <= completed word.
//  ADD lasts exactly WIDTH edges; a/b/in_valid ignored throughout.
//  DONE: out_valid=1; sum/carry held stable while out_ready=0 (unlimited stall).
//   Edge with out_ready=1: -> IDLE, out_valid=0 next cycle.
//  Latency: accept edge E; out_valid high after edge E+WIDTH.
//  No same-cycle accept+complete: in_ready=0 in DONE; min issue interval WIDTH+2 cycles.
//  sum/carry hold last result outside DONE; meaningful only while out_valid=1.
//  WIDTH=1: ADD lasts one edge; sum=a^b, carry=a&b.
//  X/Z on a/b propagate; no masking.
//  Reset mid-ADD or mid-DONE: operation aborted, no result produced, reset values immediately.
//  in_valid held high across back-to-back transactions: new accept on first IDLE edge.
// TESTING
//  WIDTH=8: a=8'h0F, b=8'h01 -> sum=8'h10, carry=0, out_valid 8 edges after accept.
//  a=8'hFF, b=8'h01 -> sum=8'h00, carry=1 (full ripple wrap-around).
//  a=8'hFF, b=8'hFF -> sum=8'hFE, carry=1; then a=0, b=0 -> sum=0, carry=0 (carry cleared on load).
//  Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum, carry stable; in_ready=0; then out_ready=1 -> IDLE.
//  Change a/b, pulse in_valid during ADD -> ignored, result from latched operands; in_ready=0.
//  Assert rst 3 edges into ADD -> outputs zero immediately, in_ready=1; next op 8'h12+8'h34 -> 8'h46, carry=0.

Source files
------------

// File: rtl/serial_bit_adder.sv
// Bit-serial WIDTH-bit adder: operands accepted over valid/ready, summed LSB-first
// one bit per clock, result offered over a second valid/ready handshake.
module serial_bit_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r,     state_s;
    logic [WIDTH-1:0]   a_sr_r,      a_sr_s;
    logic [WIDTH-1:0]   b_sr_r,      b_sr_s;
    logic               c_r,         c_s;
    logic [CNT_W-1:0]   cnt_r,       cnt_s;
    logic [WIDTH-1:0]   sum_r,       sum_s;
    logic               carry_r,     carry_s;
    logic               in_ready_r,  in_ready_s;
    logic               out_valid_r, out_valid_s;
    logic               bit_sum_s;
    logic               bit_carry_s;
    logic [WIDTH-1:0]   a_shift_s;

    function automatic logic majority3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign bit_sum_s   = a_sr_r[0] ^ b_sr_r[0] ^ c_r;
    assign bit_carry_s = majority3(a_sr_r[0], b_sr_r[0], c_r);

    // Sum bits fill the A shift register from the top as its operand bits drain out.
    if (WIDTH == 1) begin : g_w1
        assign a_shift_s = bit_sum_s;
    end else begin : g_wn
        assign a_shift_s = {bit_sum_s, a_sr_r[WIDTH-1:1]};
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_s = state_r;
        a_sr_s  = a_sr_r;
        b_sr_s  = b_sr_r;
        c_s     = c_r;
        cnt_s   = cnt_r;
        sum_s   = sum_r;
        carry_s = carry_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    a_sr_s  = a;
                    b_sr_s  = b;
                    c_s     = 1'b0;
                    cnt_s   = '0;
                    state_s = ADD;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                a_sr_s = a_shift_s;
                b_sr_s = b_sr_r >> 1;
                c_s    = bit_carry_s;
                cnt_s  = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_CNT) begin
                    state_s = DONE;
                    sum_s   = a_shift_s;
                    carry_s = bit_carry_s;
                end else begin
                    state_s = ADD;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        in_ready_s  = (state_s == IDLE);
        out_valid_s = (state_s == DONE);
    end

    // State and datapath registers; handshake flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            a_sr_r      <= '0;
            b_sr_r      <= '0;
            c_r         <= 1'b0;
            cnt_r       <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            a_sr_r      <= a_sr_s;
            b_sr_r      <= b_sr_s;
            c_r         <= c_s;
            cnt_r       <= cnt_s;
            sum_r       <= sum_s;
            carry_r     <= carry_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign carry     = carry_r;

endmodule

// File: tb/tb_serial_bit_adder.sv
// Self-checking bench for serial_bit_adder (WIDTH=8): directed corner cases plus
// randomized operands checked against plain integer addition.
module tb_serial_bit_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;

    int total = 0;
    int bad   = 0;

    serial_bit_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One full transaction; caller is at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int stall, input bit disturb);
        logic [W:0] expv;
        int lat;
        expv = {1'b0, ta} + {1'b0, tb_v};
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            if (disturb) begin
                a = W'($urandom);
                b = W'($urandom);
                in_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'(W));
        check("sum", 32'(sum), 32'(expv[W-1:0]));
        check("carry", 32'(carry), 32'(expv[W]));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_ready", 32'(in_ready), 32'd0);
            check("stall_sum", 32'(sum), 32'(expv[W-1:0]));
            check("stall_carry", 32'(carry), 32'(expv[W]));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h0F, 8'h01, 0, 1'b0);
        run_op(8'hFF, 8'h01, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 0, 1'b0);
        run_op(8'h00, 8'h00, 0, 1'b0);
        run_op(8'hA5, 8'h5A, 5, 1'b0);
        run_op(8'h3C, 8'hC4, 0, 1'b1);

        // Abort mid-ADD with an asynchronous reset.
        a = 8'hFF;
        b = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_carry", 32'(carry), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(8'h12, 8'h34, 0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
